rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_write_arbiter_if.sv | 47 ++++
 rtl/rf_warb_starve_cnt.sv | 38 +++
 rtl/rf_write_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared widths and arbiter state encoding for rf_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

   localparam int c_DATA_W = 32;
   localparam int c_ADDR_W = 5;

   typedef enum logic [0:0] {
      PRIO_A  = 1'b0,
      FORCE_B = 1'b1
   } arbState_e;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter_if
//  Description : Requester A/B handshakes plus the registered register-file
//                write port of the writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if
   import rf_pkg::*;
#(
   parameter int DATA_W = c_DATA_W,
   parameter int ADDR_W = c_ADDR_W
) ();

   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;

   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              grant_b_q;

   // Requester / register-file side
   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      input  a_ready, b_ready,
      input  rf_we, rf_waddr, rf_wdata, grant_b_q
   );

   // Arbiter side
   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      output a_ready, b_ready,
      output rf_we, rf_waddr, rf_wdata, grant_b_q
   );

endinterface : rf_write_arbiter_if
`default_nettype wire

// File: rtl/rf_warb_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : rf_warb_starve_cnt
//  Description : Saturating count of consecutive B denials; hit flags the
//                denial that brings the count to STARVE_LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_warb_starve_cnt #(
   parameter int STARVE_LIMIT = 4
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic inc,
   input  wire logic clr,
   output logic      hit
);

   localparam logic [3:0] c_LIMIT    = 4'(STARVE_LIMIT);
   localparam logic [3:0] c_LIMIT_M1 = 4'(STARVE_LIMIT - 1);

   logic [3:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 4'd0;
      end else if (clr) begin
         r_cnt <= 4'd0;
      end else if (inc && (r_cnt < c_LIMIT)) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   // Fires in the cycle whose denial reaches the limit so the forced grant
   // lands on the very next cycle.
   assign hit = inc && !clr && (r_cnt >= c_LIMIT_M1);

endmodule : rf_warb_starve_cnt
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Two-requester register-file write arbiter, A has priority;
//                optional anti-starvation for B under RF_WARB_STARVE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int DATA_W       = c_DATA_W,
   parameter int ADDR_W       = c_ADDR_W,
   parameter int STARVE_LIMIT = 4
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   rf_write_arbiter_if.slave bus
);

   logic              w_aReady;
   logic              w_bReady;
   logic              w_aXfer;
   logic              w_bXfer;

   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_grantB;

   assign w_aXfer = bus.a_valid && w_aReady;
   assign w_bXfer = bus.b_valid && w_bReady;

`ifdef RF_WARB_STARVE_EN
   arbState_e r_state;
   arbState_e w_stateNext;
   logic      w_starveInc;
   logic      w_starveClr;
   logic      w_starveHit;

   assign w_starveInc = bus.b_valid && !w_bReady;
   assign w_starveClr = !bus.b_valid || w_bXfer;

   rf_warb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starveCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_starveInc),
      .clr   (w_starveClr),
      .hit   (w_starveHit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PRIO_A;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      w_aReady    = 1'b0;
      w_bReady    = 1'b0;
      if (rst_n) begin
         case (r_state)
            PRIO_A: begin
               w_aReady = bus.a_valid;
               w_bReady = bus.b_valid && !bus.a_valid;
               if (w_starveHit) begin
                  w_stateNext = FORCE_B;
               end
            end
            FORCE_B: begin
               w_bReady = bus.b_valid;
               w_aReady = bus.a_valid && !bus.b_valid;
               if (!bus.b_valid || w_bXfer) begin
                  w_stateNext = PRIO_A;
               end
            end
         endcase
      end
   end
`else
   // Fixed priority A; the starvation limit has no effect in this build.
   logic w_unusedLimit;
   assign w_unusedLimit = (STARVE_LIMIT > 0);

   always_comb begin
      w_aReady = rst_n && bus.a_valid;
      w_bReady = rst_n && bus.b_valid && !bus.a_valid;
   end
`endif

   // Index 0 is hardwired in the register file: accept it, but never write it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_grantB <= 1'b0;
      end else if (w_aXfer) begin
         r_we     <= (bus.a_addr != '0);
         r_waddr  <= bus.a_addr;
         r_wdata  <= bus.a_data;
         r_grantB <= 1'b0;
      end else if (w_bXfer) begin
         r_we     <= (bus.b_addr != '0);
         r_waddr  <= bus.b_addr;
         r_wdata  <= bus.b_data;
         r_grantB <= 1'b1;
      end else begin
         r_we     <= 1'b0;
      end
   end

   assign bus.a_ready   = w_aReady;
   assign bus.b_ready   = w_bReady;
   assign bus.rf_we     = r_we;
   assign bus.rf_waddr  = r_waddr;
   assign bus.rf_wdata  = r_wdata;
   assign bus.grant_b_q = r_grantB;

endmodule : rf_write_arbiter
`default_nettype wire
